// File: rtl/irt_issue_scheduler.sv
// Instruction register table scheduler: in-order allocate/retire of buffer slots,
// out-of-order issue of the oldest hazard-free slot, out-of-order completion.
module irt_issue_scheduler #(
    parameter int regnum = 32,
    parameter int bs     = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    input  logic [$clog2(regnum)-1:0] alloc_rs1,
    input  logic [$clog2(regnum)-1:0] alloc_rs2,
    input  logic [$clog2(regnum)-1:0] alloc_rd,
    output logic [$clog2(bs)-1:0]     alloc_index,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [$clog2(bs)-1:0]     issue_index,
    input  logic                      complete_valid,
    input  logic [$clog2(bs)-1:0]     complete_index,
    output logic                      retire_valid,
    output logic [$clog2(bs)-1:0]     retire_index,
    output logic [$clog2(bs):0]       count,
    output logic                      full,
    output logic                      empty
);
    localparam int RW = $clog2(regnum);
    localparam int SW = $clog2(bs);

    typedef enum logic [1:0] {FREE, WAIT, ISSUED, DONE} slot_state_t;

    slot_state_t       st      [bs];
    logic [regnum-1:0] rs_mask [bs];
    logic [regnum-1:0] rd_mask [bs];
    logic [SW-1:0]     head;
    logic [SW-1:0]     tail;

    logic              alloc_fire;
    logic              issue_fire;
    logic [regnum-1:0] acc_rd;
    logic [regnum-1:0] acc_rs;
    logic [SW-1:0]     slot;

    // x0 is masked out so it can never create a hazard.
    function automatic logic [regnum-1:0] reg_mask(input logic [RW-1:0] r);
        logic [regnum-1:0] m;
        m    = '0;
        m[r] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    assign full         = (count == (SW+1)'(bs));
    assign empty        = (count == '0);
    assign alloc_ready  = !full;
    assign alloc_index  = tail;
    assign alloc_fire   = alloc_valid && alloc_ready;
    assign retire_valid = (st[head] == DONE);
    assign retire_index = head;
    assign issue_fire   = issue_valid && issue_ready;

    // Walk slots oldest-first, accumulating the masks of older in-flight slots;
    // the first WAIT slot clear of all three hazards wins.
    always_comb begin
        issue_valid = 1'b0;
        issue_index = '0;
        acc_rd      = '0;
        acc_rs      = '0;
        slot        = '0;
        for (int k = 0; k < bs; k++) begin
            slot = head + SW'(k);
            if (!issue_valid && st[slot] == WAIT
                && ((acc_rd & (rs_mask[slot] | rd_mask[slot])) == '0)
                && ((acc_rs & rd_mask[slot]) == '0)) begin
                issue_valid = 1'b1;
                issue_index = slot;
            end
            if (st[slot] == WAIT || st[slot] == ISSUED)
                acc_rd = acc_rd | rd_mask[slot];
            if (st[slot] == WAIT)
                acc_rs = acc_rs | rs_mask[slot];
        end
    end

    // Issue, complete, retire and allocate always touch distinct slots
    // (WAIT, ISSUED, DONE and FREE respectively), so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < bs; i++) st[i] <= FREE;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            for (int i = 0; i < bs; i++) st[i] <= FREE;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_fire) begin
                st[tail] <= WAIT;
                tail     <= tail + SW'(1);
            end
            if (issue_fire)
                st[issue_index] <= ISSUED;
            if (complete_valid && st[complete_index] == ISSUED)
                st[complete_index] <= DONE;
            if (retire_valid) begin
                st[head] <= FREE;
                head     <= head + SW'(1);
            end
            count <= count + (SW+1)'(alloc_fire) - (SW+1)'(retire_valid);
        end
    end

    // Masks are only consulted while a slot is occupied, so they need no reset.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            rs_mask[tail] <= reg_mask(alloc_rs1) | reg_mask(alloc_rs2);
            rd_mask[tail] <= reg_mask(alloc_rd);
        end
    end

endmodule

// File: tb/tb_irt_issue_scheduler.sv
// Randomized and directed bench for irt_issue_scheduler against a program-order queue model.
module tb_irt_issue_scheduler;
    localparam int REGNUM = 32;
    localparam int BS     = 16;
    localparam int RW     = 5;
    localparam int SW     = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          alloc_valid;
    logic          alloc_ready;
    logic [RW-1:0] alloc_rs1;
    logic [RW-1:0] alloc_rs2;
    logic [RW-1:0] alloc_rd;
    logic [SW-1:0] alloc_index;
    logic          issue_valid;
    logic          issue_ready;
    logic [SW-1:0] issue_index;
    logic          complete_valid;
    logic [SW-1:0] complete_index;
    logic          retire_valid;
    logic [SW-1:0] retire_index;
    logic [SW:0]   count;
    logic          full;
    logic          empty;

    irt_issue_scheduler #(.regnum(REGNUM), .bs(BS)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_rs1(alloc_rs1), .alloc_rs2(alloc_rs2), .alloc_rd(alloc_rd),
        .alloc_index(alloc_index),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_index(issue_index),
        .complete_valid(complete_valid), .complete_index(complete_index),
        .retire_valid(retire_valid), .retire_index(retire_index),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef enum int {M_WAIT, M_ISSUED, M_DONE} mst_t;
    typedef struct {
        int   slot;
        int   rs1;
        int   rs2;
        int   rd;
        mst_t st;
    } ent_t;

    ent_t q[$];
    int   m_tail = 0;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit hazard_free(input int i);
        for (int j = 0; j < i; j++) begin
            if (q[j].st != M_DONE && q[j].rd != 0 &&
                (q[j].rd == q[i].rs1 || q[j].rd == q[i].rs2 || q[j].rd == q[i].rd))
                return 1'b0;
            if (q[j].st == M_WAIT && q[i].rd != 0 &&
                (q[i].rd == q[j].rs1 || q[i].rd == q[j].rs2))
                return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int oldest_ready();
        for (int i = 0; i < q.size(); i++)
            if (q[i].st == M_WAIT && hazard_free(i)) return i;
        return -1;
    endfunction

    // One clock: drive at negedge, check model outputs, update model at posedge.
    task automatic cycle(input bit av, input int r1, input int r2, input int rd,
                         input bit ir, input bit cv, input int ci, input bit fl);
        int   oi;
        bit   m_ret;
        bit   m_alloc;
        ent_t e;
        alloc_valid    = av;
        alloc_rs1      = RW'(r1);
        alloc_rs2      = RW'(r2);
        alloc_rd       = RW'(rd);
        issue_ready    = ir;
        complete_valid = cv;
        complete_index = SW'(ci);
        flush          = fl;
        #1;
        oi    = oldest_ready();
        m_ret = (q.size() > 0) && (q[0].st == M_DONE);
        chk("issue_valid", int'(issue_valid), int'(oi >= 0));
        if (oi >= 0) chk("issue_index", int'(issue_index), q[oi].slot);
        chk("retire_valid", int'(retire_valid), int'(m_ret));
        if (m_ret) chk("retire_index", int'(retire_index), q[0].slot);
        chk("count", int'(count), q.size());
        chk("full", int'(full), int'(q.size() == BS));
        chk("empty", int'(empty), int'(q.size() == 0));
        chk("alloc_ready", int'(alloc_ready), int'(q.size() < BS));
        chk("alloc_index", int'(alloc_index), m_tail);
        @(posedge clk);
        if (fl) begin
            q.delete();
            m_tail = 0;
        end else begin
            m_alloc = av && (q.size() < BS);
            if (cv)
                for (int i = 0; i < q.size(); i++)
                    if (q[i].slot == ci && q[i].st == M_ISSUED) q[i].st = M_DONE;
            if (oi >= 0 && ir) q[oi].st = M_ISSUED;
            if (m_ret) void'(q.pop_front());
            if (m_alloc) begin
                e.slot = m_tail; e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.st = M_WAIT;
                q.push_back(e);
                m_tail = (m_tail + 1) % BS;
            end
        end
        @(negedge clk);
    endtask

    task automatic alloc(input int r1, input int r2, input int rd);
        cycle(1'b1, r1, r2, rd, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic idle(input bit ir);
        cycle(1'b0, 0, 0, 0, ir, 1'b0, 0, 1'b0);
    endtask

    task automatic complete(input int ci, input bit ir);
        cycle(1'b0, 0, 0, 0, ir, 1'b1, ci, 1'b0);
    endtask

    task automatic do_flush();
        cycle(1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b1);
    endtask

    initial begin
        int issued[$];
        bit av, ir, cv, fl;
        int ci;

        rst_n = 1'b0; flush = 1'b0; alloc_valid = 1'b0; alloc_rs1 = '0; alloc_rs2 = '0;
        alloc_rd = '0; issue_ready = 1'b0; complete_valid = 1'b0; complete_index = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(1'b0);

        // First allocation after reset
        alloc(1, 2, 3);
        chk("first_issue_valid", int'(issue_valid), 1);
        chk("first_issue_index", int'(issue_index), 0);
        chk("first_count", int'(count), 1);
        do_flush();

        // RAW: B reads A's destination
        alloc(0, 0, 5);
        alloc(5, 0, 6);
        idle(1'b1);
        chk("raw_b_blocked", int'(issue_valid), 0);
        complete(0, 1'b0);
        chk("raw_b_ready", int'(issue_index), 1);
        chk("raw_a_retire", int'(retire_index), 0);
        idle(1'b1);
        do_flush();

        // WAR / WAW ordering with issue_ready held high
        alloc(7, 0, 8);
        alloc(0, 0, 7);
        alloc(0, 0, 8);
        chk("war_a_first", int'(issue_index), 0);
        idle(1'b1);
        chk("war_b_second", int'(issue_index), 1);
        idle(1'b1);
        chk("waw_c_blocked", int'(issue_valid), 0);
        complete(0, 1'b1);
        chk("waw_c_third", int'(issue_index), 2);
        idle(1'b1);
        do_flush();

        // x0 never creates hazards; independent younger slot passes a stalled one
        alloc(0, 0, 0);
        alloc(0, 0, 0);
        idle(1'b1);
        chk("x0_b_ready", int'(issue_index), 1);
        idle(1'b1);
        alloc(0, 0, 9);
        alloc(9, 0, 12);
        alloc(10, 0, 11);
        idle(1'b1);
        chk("indep_d_first", int'(issue_index), 4);
        idle(1'b1);
        do_flush();

        // Fill, reject overflow, complete in reverse, retire in order, wrap
        for (int i = 0; i < BS; i++) alloc(0, 0, i + 1);
        chk("full_flag", int'(full), 1);
        alloc(1, 1, 1);
        chk("overflow_ignored", int'(count), BS);
        for (int i = 0; i < BS; i++) idle(1'b1);
        for (int i = BS - 1; i >= 0; i--) complete(i, 1'b0);
        for (int i = 0; i < BS; i++) idle(1'b0);
        chk("wrap_alloc_index", int'(alloc_index), 0);
        alloc(0, 0, 4);
        idle(1'b1);

        // Flush with issued slots, then a stale completion
        do_flush();
        for (int i = 0; i < 5; i++) alloc(i + 1, 0, i + 10);
        idle(1'b1);
        idle(1'b1);
        do_flush();
        chk("flush_empty", int'(empty), 1);
        complete(0, 1'b0);
        chk("flush_stale_complete", int'(issue_valid), 0);

        // Randomized traffic with hazards on a small register set
        for (int n = 0; n < 3000; n++) begin
            av = ($urandom_range(0, 99) < 60);
            ir = ($urandom_range(0, 99) < 70);
            fl = ($urandom_range(0, 199) == 0);
            issued.delete();
            foreach (q[i]) if (q[i].st == M_ISSUED) issued.push_back(q[i].slot);
            cv = 1'b0;
            ci = 0;
            if (issued.size() > 0 && $urandom_range(0, 99) < 60) begin
                cv = 1'b1;
                ci = issued[$urandom_range(0, issued.size() - 1)];
            end else if ($urandom_range(0, 99) < 10) begin
                cv = 1'b1;
                ci = $urandom_range(0, BS - 1);
            end
            cycle(av, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  ir, cv, ci, fl);
        end

        // Asynchronous reset mid-cycle, no clock edge needed
        do_flush();
        alloc(0, 0, 1);
        alloc(0, 0, 2);
        idle(1'b1);
        complete(0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_count", int'(count), 0);
        chk("async_empty", int'(empty), 1);
        chk("async_issue_valid", int'(issue_valid), 0);
        chk("async_retire_valid", int'(retire_valid), 0);
        q.delete();
        m_tail = 0;
        @(negedge clk);
        rst_n = 1'b1;
        alloc(3, 0, 4);
        chk("post_reset_slot", int'(issue_index), 0);
        idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/irt_issue_scheduler.md
Name: irt_issue_scheduler

Overview:
- Sequences the instruction register table: allocates buffer slots in program order and tracks per-slot source/destination register masks.
- Issues the oldest slot whose hazards are cleared, and retires completed slots in order.
- Sits between decode (allocation side) and the execution units (issue/complete side) of the ESM module.
- Out-of-order issue and completion, in-order allocation and retirement.

Parameters:
regnum, 32, number of architectural registers; register index width is clog2(regnum)
bs, 16, buffer slots; power of two; slot index width is clog2(bs)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all slots
alloc_valid  input  1  decode offers an instruction
alloc_ready  output  1  slot available (= !full)
alloc_rs1  input  clog2(regnum)  source register 1
alloc_rs2  input  clog2(regnum)  source register 2
alloc_rd  input  clog2(regnum)  destination register
alloc_index  output  clog2(bs)  slot assigned on handshake (= tail)
issue_valid  output  1  a ready slot is presented
issue_ready  input  1  execution accepts it
issue_index  output  clog2(bs)  presented slot
complete_valid  input  1  execution finished a slot
complete_index  input  clog2(bs)  finished slot
retire_valid  output  1  head slot retires this cycle
retire_index  output  clog2(bs)  retiring slot (= head)
count  output  clog2(bs)+1  occupied slots
full  output  1  count == bs
empty  output  1  count == 0

Behaviour:
- Per-slot storage: rs_mask[regnum], rd_mask[regnum], and state {FREE, WAIT, ISSUED, DONE}.
- Masks are one-hot OR of the slot's registers.
- Bit 0 (x0) is always cleared in both masks, so x0 never creates a hazard.
- head/tail are clog2(bs)-bit circular pointers; count disambiguates full vs empty.
- Reset (async, rst_n low): all slots FREE, head=tail=0, count=0; full=0, empty=1, issue_valid=0, retire_valid=0.
- Allocate on alloc_valid && alloc_ready:
  - slot[tail] <= WAIT with its masks; tail++ (wraps bs-1 -> 0).
  - alloc_valid while full is ignored; no state change.
- Hazard check for WAIT slot S, against every older occupied slot O (from head up to S, exclusive):
  - RAW: O not DONE and rd_mask[O] & rs_mask[S] != 0.
  - WAR: O in WAIT and rs_mask[O] & rd_mask[S] != 0.
  - WAW: O not DONE and rd_mask[O] & rd_mask[S] != 0.
  - S is ready when none of the three hold.
- Issue:
  - issue_valid is combinational from registered state: asserted when any slot is ready.
  - issue_index is the ready slot oldest by distance from head, wrap-aware.
  - On issue_valid && issue_ready, slot <= ISSUED at that edge.
  - One issue per cycle. issue_index must stay stable while issue_ready is low unless an older slot becomes ready.
- Complete: complete_valid with the slot in ISSUED -> DONE at the edge. Complete on a slot in any other state is ignored.
- Retire:
  - retire_valid = (slot[head] == DONE), combinational; retire_index = head.
  - At that edge the slot becomes FREE and head++.
  - One retire per cycle.
- Latencies:
  - Allocate at edge N -> slot eligible for issue in cycle N+1 (no same-cycle bypass).
  - Complete at edge N -> dependents ready and retire_valid visible in cycle N+1.
- Simultaneous events:
  - Alloc, issue, complete and retire in one cycle are all honoured.
  - count updates by +alloc -retire.
  - Alloc while full with a same-cycle retire is NOT accepted: alloc_ready depends only on registered full.
- flush: at the edge, all slots FREE, head=tail=0, count=0. It overrides alloc, issue, complete and retire in the same cycle.
- Reset asserted mid-operation clears everything immediately; the first allocation after release lands in slot 0.
- rs1 == rs2, or rd equal to a source, is legal; mask bits simply coincide.

Test Plan:
- Reset then allocate (rs1=1,rs2=2,rd=3) -> alloc_index=0; in the next cycle issue_valid=1, issue_index=0, count=1, empty=0.
- RAW:
  - Allocate A(rd=5), then B(rs1=5,rd=6); issue A -> B stays un-ready.
  - Complete A -> B issue_valid next cycle; A retires the same cycle (retire_index=0).
- WAR/WAW: A(rs1=7,rd=8), B(rd=7), C(rd=8).
  - B blocked until A is ISSUED.
  - C blocked until A is DONE.
  - With issue_ready held high, order is A, B, C.
- x0 and independence:
  - A(rd=0), B(rs1=0,rd=0) -> both ready; issue order A then B.
  - Independent D ahead of a stalled E issues first.
- Full and wrap:
  - Allocate 16 -> full=1, alloc_ready=0; a 17th alloc_valid is ignored.
  - Complete all out of order (15..0) -> retire indices 0..15 in order.
  - Subsequent alloc_index=0 after wrap.
- Flush/reset: flush with 5 slots (2 ISSUED) -> next cycle count=0, empty=1, issue_valid=0; complete of an old index is ignored.
- Async reset: rst_n low mid-cycle clears outputs without waiting for a clock edge.
